// File: rtl/cat_rec_sequencer.sv
// rtl/cat_rec_sequencer.sv - pixel x weight dot-product sequencer with sign classification; define CAT_REC_BIAS_EN to add the bias in FINAL
module cat_rec_sequencer #(
    parameter int AMBA_WORD        = 32,
    parameter int AMBA_ADDR_DEPTH  = 12,
    parameter int PIXEL_WIDTH      = 8,
    parameter int WEIGHT_PRECISION = 5,
    parameter int ITERATION        = 4096,
    parameter int RESULT_WIDTH     = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    output logic [AMBA_ADDR_DEPTH:0]             pix_addr,
    input  logic [AMBA_WORD-1:0]                 pix_data,
    output logic [AMBA_ADDR_DEPTH:0]             wgt_addr,
    input  logic [3*WEIGHT_PRECISION-1:0]        wgt_data,
    input  logic signed [15:0]                   bias,
    output logic signed [RESULT_WIDTH-1:0]       current_result,
    output logic                                 cat_rec_out,
    output logic                                 done_iteration,
    output logic                                 done_flag,
    output logic                                 busy
);

    localparam int PW     = PIXEL_WIDTH;
    localparam int WP     = WEIGHT_PRECISION;
    localparam int PROD_W = PW + 1 + WP;
    localparam int SUM_W  = PROD_W + 2;
    localparam logic [AMBA_ADDR_DEPTH:0] ADDR_ONE  = (AMBA_ADDR_DEPTH+1)'(1);
    localparam logic [AMBA_ADDR_DEPTH:0] LAST_ADDR = (AMBA_ADDR_DEPTH+1)'(ITERATION);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        FINAL,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic signed [RESULT_WIDTH-1:0] acc;
    logic        [AMBA_WORD-1:0]    pix_word;
    logic signed [PROD_W-1:0]       px_ext;
    logic signed [PROD_W-1:0]       wt_ext;
    logic signed [PROD_W-1:0]       prod;
    logic signed [SUM_W-1:0]        word_sum;
    logic signed [RESULT_WIDTH-1:0] sum_ext;
    logic signed [RESULT_WIDTH-1:0] bias_ext;
    logic signed [RESULT_WIDTH-1:0] final_val;
    logic                           unused_ok;

    // An unknown pixel word (uninitialised bank) must not poison the accumulator.
    assign pix_word = (^pix_data === 1'bx) ? '0 : pix_data;

    always_comb begin
        px_ext   = '0;
        wt_ext   = '0;
        prod     = '0;
        word_sum = '0;
        for (int k = 0; k < 3; k++) begin
            px_ext   = {{(WP+1){1'b0}}, pix_word[k*PW +: PW]};
            wt_ext   = {{(PW+1){wgt_data[k*WP+WP-1]}}, wgt_data[k*WP +: WP]};
            prod     = px_ext * wt_ext;
            word_sum = word_sum + {{2{prod[PROD_W-1]}}, prod};
        end
    end

    assign sum_ext  = {{(RESULT_WIDTH-SUM_W){word_sum[SUM_W-1]}}, word_sum};
    assign bias_ext = {{(RESULT_WIDTH-16){bias[15]}}, bias};

`ifdef CAT_REC_BIAS_EN
    assign final_val = acc + bias_ext;
`else
    assign final_val = acc;
`endif

    assign unused_ok = ^{bias_ext, pix_word[AMBA_WORD-1:3*PW]};

    assign wgt_addr       = pix_addr - ADDR_ONE;
    assign current_result = acc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        busy           = 1'b0;
        done_iteration = 1'b0;
        done_flag      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (pix_addr == LAST_ADDR) state_d = DRAIN;
            end
            DRAIN: begin
                busy           = 1'b1;
                done_iteration = 1'b1;
                state_d        = FINAL;
            end
            FINAL: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done_flag = 1'b1;
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bank data lags the address by a cycle, so RUN's first cycle has nothing to add.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc         <= '0;
            pix_addr    <= ADDR_ONE;
            cat_rec_out <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    pix_addr <= ADDR_ONE;
                    if (start) begin
                        acc         <= '0;
                        cat_rec_out <= 1'b0;
                    end
                end
                RUN: begin
                    if (pix_addr != ADDR_ONE) acc <= acc + sum_ext;
                    pix_addr <= (pix_addr == LAST_ADDR) ? ADDR_ONE : pix_addr + ADDR_ONE;
                end
                DRAIN: begin
                    acc <= acc + sum_ext;
                end
                FINAL: begin
                    acc         <= final_val;
                    cat_rec_out <= (final_val > 0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cat_rec_sequencer.sv
// tb/tb_cat_rec_sequencer.sv - scoreboard bench for cat_rec_sequencer with ITERATION=4
module tb_cat_rec_sequencer;

    localparam int ITER = 4;
    localparam int AD   = 12;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [AD:0]         pix_addr;
    logic [31:0]         pix_data = '0;
    logic [AD:0]         wgt_addr;
    logic [14:0]         wgt_data = '0;
    logic signed [15:0]  bias = '0;
    logic signed [31:0]  current_result;
    logic                cat_rec_out;
    logic                done_iteration;
    logic                done_flag;
    logic                busy;

    logic [31:0] pix_mem [0:ITER];
    logic [14:0] wgt_mem [0:ITER-1];

    typedef struct {
        int result;
        bit out;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    cat_rec_sequencer #(
        .AMBA_WORD(32), .AMBA_ADDR_DEPTH(AD), .PIXEL_WIDTH(8),
        .WEIGHT_PRECISION(5), .ITERATION(ITER), .RESULT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .pix_addr(pix_addr), .pix_data(pix_data),
        .wgt_addr(wgt_addr), .wgt_data(wgt_data),
        .bias(bias), .current_result(current_result),
        .cat_rec_out(cat_rec_out), .done_iteration(done_iteration),
        .done_flag(done_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous-read banks: data appears one cycle after the address.
    always @(posedge clk) begin
        pix_data <= (pix_addr <= ITER) ? pix_mem[pix_addr] : 32'd0;
        wgt_data <= (wgt_addr < ITER) ? wgt_mem[wgt_addr] : 15'd0;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int word_sum(input logic [31:0] p, input logic [14:0] w);
        int s = 0;
        logic signed [4:0] wk;
        for (int k = 0; k < 3; k++) begin
            wk = w[k*5 +: 5];
            s += int'(p[k*8 +: 8]) * int'(wk);
        end
        return s;
    endfunction

    task automatic fill(input logic [31:0] p, input logic [14:0] w);
        for (int i = 0; i < ITER; i++) begin
            pix_mem[i+1] = p;
            wgt_mem[i]   = w;
        end
        pix_mem[0] = '0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < ITER; i++) begin
            pix_mem[i+1] = $urandom;
            wgt_mem[i]   = 15'($urandom);
        end
        pix_mem[0] = '0;
    endtask

    task automatic push_expected(input logic signed [15:0] b);
        int acc = 0;
        exp_t e;
        for (int i = 0; i < ITER; i++) acc += word_sum(pix_mem[i+1], wgt_mem[i]);
`ifdef CAT_REC_BIAS_EN
        acc += int'(b);
`endif
        e.result = acc;
        e.out    = (acc > 0);
        sb.push_back(e);
    endtask

    // mode 0: start held high through DONE; mode 1: start pulsed, re-pulsed mid-RUN.
    task automatic run(input logic signed [15:0] b, input int mode);
        int   cyc = 1;
        bit   seen = 0;
        int   di_cnt = 0;
        int   di_cyc = 0;
        exp_t e;
        logic signed [31:0] held;
        bias = b;
        push_expected(b);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        while (!seen && cyc < 40) begin
            @(negedge clk);
            if (mode == 1) start = (cyc == 2);
            if (cyc <= ITER) begin
                check("pix_addr", pix_addr, cyc);
                check("wgt_addr", wgt_addr, cyc - 1);
            end
            if (done_iteration) begin
                di_cnt++;
                di_cyc = cyc;
            end
            if (done_flag) begin
                seen = 1;
                check("done_latency", cyc, ITER + 3);
                check("busy_in_done", busy, 0);
                if (sb.size() == 0) check("sb_empty", 0, 1);
                else begin
                    e = sb.pop_front();
                    check("result", current_result, e.result);
                    check("cat_rec_out", cat_rec_out, e.out);
                end
            end else begin
                check("busy_run", busy, 1);
                cyc++;
            end
        end
        if (!seen) check("done_timeout", 0, 1);
        check("done_iter_count", di_cnt, 1);
        check("done_iter_cycle", di_cyc, ITER + 1);
        held = current_result;
        if (mode == 0) begin
            repeat (4) begin
                @(negedge clk);
                check("done_hold", done_flag, 1);
                check("no_restart", busy, 0);
                check("result_hold", current_result, held);
            end
            start = 1'b0;
        end
        @(negedge clk);
        check("idle_done_flag", done_flag, 0);
        @(negedge clk);
        check("idle_busy", busy, 0);
    endtask

    task automatic reset_abort();
        int dones = 0;
        int cyc = 1;
        fill(32'h00030201, 15'b00010_11111_00001);
        bias = 16'sd0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        while (cyc < 3) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        check("partial_acc", current_result, word_sum(pix_mem[1], wgt_mem[0]));
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_result", current_result, 0);
        check("abort_done", done_flag, 0);
        check("abort_pix_addr", pix_addr, 1);
        rst = 1'b1;
        start = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done_flag) dones++;
        end
        check("abort_no_done", dones, 0);
    endtask

    initial begin
        fill(32'd0, 15'd0);
        rst   = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done_flag", done_flag, 0);
        check("rst_done_iter", done_iteration, 0);
        check("rst_result", current_result, 0);
        check("rst_cat_rec_out", cat_rec_out, 0);
        check("rst_pix_addr", pix_addr, 1);
        check("rst_wgt_addr", wgt_addr, 0);
        start = 1'b0;
        rst   = 1'b1;
        repeat (2) @(negedge clk);

        fill(32'h00010101, 15'b00001_00001_00001);
        run(16'sd0, 0);
        fill(32'h00FFFFFF, 15'b10000_10000_10000);
        run(16'sd0, 1);
        fill(32'h00000000, 15'b01111_01111_01111);
        run(16'sd0, 1);
        run(16'sd5, 0);
        run(-16'sd7, 1);
        for (int i = 0; i < 3; i++) begin
            fill_random();
            run(16'($urandom_range(0, 65535)), i % 2);
        end
        reset_abort();
        fill(32'hAB10FF02, 15'b11111_00011_10101);
        run(16'sd100, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
